// File: rtl/ravenoc_axi_pkt_writer.sv
// ravenoc_axi_pkt_writer: turns one packet command plus a beat stream into a single AXI4 INCR write burst
//
// Ports:
//   clk_axi, arst_axi          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_addr start address, cmd_len beats-1)
//   s_data_valid/s_data_ready  beat stream in (s_data payload), passed straight through to W
//   done_valid/done_resp       one-cycle completion pulse with the AXI response
//   busy, err_cnt              not-idle flag, saturating count of non-OKAY completions
//   aw*/w*/b*                  AXI4 write master channels
module ravenoc_axi_pkt_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ALEN_WIDTH = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk_axi,
    input  logic                    arst_axi,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [ALEN_WIDTH-1:0]   cmd_len,
    input  logic                    s_data_valid,
    output logic                    s_data_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    done_valid,
    output logic [1:0]              done_resp,
    output logic                    busy,
    output logic [7:0]              err_cnt,
    output logic                    awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [ALEN_WIDTH-1:0]   awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, CHK, AW, W, B, DONE} state_t;

    state_t                state, state_nx;
    logic [ALEN_WIDTH-1:0] beat_cnt;
    logic                  misaligned, cross4k, reject;
    logic [31:0]           span_end;

    // awaddr/awlen double as the registered command, so they are stable through AW
    assign misaligned = (awaddr & ADDR_WIDTH'(BYTES - 1)) != '0;
    assign span_end   = 32'(awaddr[11:0]) + ((32'(awlen) + 32'd1) << SZ);
    assign cross4k    = span_end > 32'd4096;
    assign reject     = misaligned || cross4k;

    assign cmd_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign awvalid      = state == AW;
    assign wvalid       = (state == W) && s_data_valid;
    assign wdata        = s_data;
    assign wlast        = (state == W) && (beat_cnt == '0);
    assign s_data_ready = (state == W) && wready;
    assign bready       = state == B;
    assign done_valid   = state == DONE;
    assign awid         = 1'(AXI_ID);
    assign awsize       = 3'(SZ);
    assign awburst      = 2'b01;
    assign wstrb        = '1;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cmd_valid ? CHK : IDLE;
            CHK:     state_nx = reject ? DONE : AW;
            AW:      state_nx = awready ? W : AW;
            W:       state_nx = (wvalid && wready && wlast) ? B : W;
            B:       state_nx = bvalid ? DONE : B;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            state     <= IDLE;
            awaddr    <= '0;
            awlen     <= '0;
            beat_cnt  <= '0;
            done_resp <= 2'b00;
            err_cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                awaddr   <= cmd_addr;
                awlen    <= cmd_len;
                beat_cnt <= cmd_len;
            end
            if (state == CHK && reject)
                done_resp <= 2'b10;
            // counter parks at 0 on the last beat rather than wrapping
            if (wvalid && wready && beat_cnt != '0)
                beat_cnt <= beat_cnt - 1'b1;
            if (state == B && bvalid)
                done_resp <= (bid == 1'(AXI_ID)) ? bresp : 2'b10;
            if (state == DONE && done_resp != 2'b00 && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ravenoc_axi_pkt_writer.sv
// tb_ravenoc_axi_pkt_writer: directed bench with a beat scoreboard for ravenoc_axi_pkt_writer
module tb_ravenoc_axi_pkt_writer;
    logic        clk_axi = 1'b0;
    logic        arst_axi;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        s_data_valid, s_data_ready;
    logic [31:0] s_data;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic        busy;
    logic [7:0]  err_cnt;
    logic        awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    exp_err  = 0;

    always #5 clk_axi = ~clk_axi;

    ravenoc_axi_pkt_writer dut (
        .clk_axi(clk_axi), .arst_axi(arst_axi),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data(s_data),
        .done_valid(done_valid), .done_resp(done_resp), .busy(busy), .err_cnt(err_cnt),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_addr = 0; cmd_len = 0;
        s_data_valid = 0; s_data = 0;
        awready = 0; wready = 0;
        bvalid = 0; bid = 0; bresp = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_s_data_ready"}, s_data_ready, 0);
        chk({tag, "_done_valid"}, done_valid, 0);
    endtask

    // Drives one command and acts as a zero-latency AW slave, a W slave whose wready
    // rises at loop cycle wwait, and a B slave returning (bi, br). Cycle 0 is the CHK cycle.
    task automatic run_cmd(input logic [31:0] a, input logic [7:0] l, input int wwait,
                           input logic [1:0] br, input logic bi, input logic early_b,
                           input logic [1:0] exp_resp, input logic exp_aw, input int abort_at);
        int beats = 0;
        int first_aw = -1;
        bit got_done = 0;
        if (exp_aw)
            for (int k = 0; k <= int'(l); k++) sb.push_back('{last: (k == int'(l)), data: 32'hA0 + k});
        @(posedge clk_axi); #1;
        cmd_valid = 1; cmd_addr = a; cmd_len = l;
        @(negedge clk_axi);
        chk("cmd_ready_on_cmd", cmd_ready, 1);
        @(posedge clk_axi); #1;
        cmd_valid = 0;
        for (int i = 0; i < 400 && !got_done; i++) begin
            s_data_valid = beats <= int'(l);
            s_data       = 32'hA0 + beats;
            awready      = 1;
            wready       = i >= wwait;
            bvalid       = early_b || beats > int'(l);
            bid          = bi;
            bresp        = br;
            @(negedge clk_axi);
            if (awvalid) begin
                if (first_aw < 0) first_aw = i;
                chk("awaddr", awaddr, a);
                chk("awlen", awlen, l);
                chk("awsize", awsize, 2);
                chk("awburst", awburst, 1);
                chk("awid", awid, 0);
            end
            if (wvalid) begin
                chk("s_data_ready_tracks_wready", s_data_ready, wready);
                chk("wstrb", wstrb, 4'hF);
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    chk("wdata", wdata, sb[0].data);
                    chk("wlast", wlast, sb[0].last);
                    if (wready) begin
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end
            if (bready && bvalid) chk("b_after_all_beats", beats, int'(l) + 1);
            if (done_valid) begin
                got_done = 1;
                chk("done_resp", done_resp, exp_resp);
            end
            if (abort_at >= 0 && beats == abort_at) break;
            @(posedge clk_axi); #1;
        end
        if (abort_at < 0) begin
            chk("done_seen", got_done, 1);
            chk("aw_seen", first_aw >= 0, exp_aw);
            if (exp_aw) chk("aw_latency", first_aw, 1);
            chk("beat_count", beats, exp_aw ? int'(l) + 1 : 0);
            chk("sb_drained", sb.size(), 0);
            if (exp_resp != 2'b00 && exp_err < 255) exp_err++;
            @(posedge clk_axi); #1;
            idle_inputs();
            @(negedge clk_axi);
            check_idle_outputs("after_done");
            chk("err_cnt", err_cnt, exp_err);
        end
    endtask

    initial begin
        arst_axi = 1;
        idle_inputs();
        repeat (2) @(posedge clk_axi);
        @(negedge clk_axi);
        check_idle_outputs("reset");
        chk("reset_awaddr", awaddr, 0);
        chk("reset_awlen", awlen, 0);
        chk("reset_done_resp", done_resp, 0);
        chk("reset_err_cnt", err_cnt, 0);
        @(posedge clk_axi); #1;
        arst_axi = 0;

        run_cmd(32'h1000, 8'd3, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, -1);
        run_cmd(32'h2000, 8'd0, 7, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, -1);
        run_cmd(32'h1002, 8'd3, 0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, -1);
        run_cmd(32'h1FF8, 8'd3, 0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, -1);
        run_cmd(32'h1FF0, 8'd3, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, -1);
        run_cmd(32'h3000, 8'd1, 0, 2'b11, 1'b0, 1'b1, 2'b11, 1'b1, -1);
        run_cmd(32'h3000, 8'd1, 0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, -1);
        for (int n = 0; n < 300; n++)
            run_cmd(32'h1001, 8'd0, 0, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, -1);
        chk("err_cnt_saturated", err_cnt, 255);

        run_cmd(32'h4000, 8'd7, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 2);
        @(posedge clk_axi); #1;
        arst_axi = 1;
        idle_inputs();
        @(negedge clk_axi);
        check_idle_outputs("mid_burst_reset");
        chk("mid_burst_reset_err_cnt", err_cnt, 0);
        @(posedge clk_axi); #1;
        arst_axi = 0;
        sb.delete();
        exp_err = 0;
        repeat (3) begin
            @(negedge clk_axi);
            chk("no_done_after_reset", done_valid, 0);
        end
        run_cmd(32'h5000, 8'd2, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
